// File: rtl/spi_rxc.sv
// SPI receive core: assembles 8/16/32-bit frames on sclk_rx, flags rxne/overrun,
// and checks an optional trailing CRC frame after a programmable number of data frames.
module spi_rxc (
    input  logic        sclk_rx,
    input  logic        spi_rx_rstn,
    input  logic        shift_in,
    input  logic [1:0]  df,
    input  logic        lsbf,
    input  logic        crc_en,
    input  logic        txonly,
    input  logic [12:0] spi_rnum_max,
    input  logic [31:0] crc_poly,
    input  logic        rx_rd_clr,
    input  logic        ovr_clr,
    output logic [31:0] spi_rx_data,
    output logic        rxne,
    output logic        ovr,
    output logic        crc_err,
    output logic [31:0] rx_crc_data_out,
    output logic        rx_crc_frm
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 5;
    localparam int unsigned FW = 13;

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_CRC  = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   bit_cnt, bit_cnt_nxt;
    logic [DW-1:0]   sr, sr_nxt;
    logic [FW-1:0]   frm_cnt, frm_cnt_nxt;
    logic [DW-1:0]   data_nxt;
    logic            rxne_nxt;
    logic            ovr_nxt;
    logic            crc_err_nxt;
    logic [DW-1:0]   crc_nxt;
    logic            crc_frm_nxt;

    logic [CW-1:0]   n_m1;
    logic [DW-1:0]   mask;
    logic [DW-1:0]   sr_in;
    logic [DW-1:0]   frame;
    logic            last;
    logic            fb;
    logic [DW-1:0]   crc_step;
    logic [FW-1:0]   limit;
    logic [FW-1:0]   frm_inc;
    logic            ovr_set;

    // Frame geometry decode and per-bit datapath values
    always_comb begin
        unique case (df)
            2'b00:   begin n_m1 = CW'(7);  mask = DW'(32'h0000_00FF); end
            2'b01:   begin n_m1 = CW'(15); mask = DW'(32'h0000_FFFF); end
            default: begin n_m1 = CW'(31); mask = DW'(32'hFFFF_FFFF); end
        endcase
        sr_in    = lsbf ? (sr | (DW'(shift_in) << bit_cnt)) : {sr[DW-2:0], shift_in};
        frame    = sr_in & mask;
        last     = (bit_cnt == n_m1);
        fb       = rx_crc_data_out[n_m1] ^ shift_in;
        crc_step = ((rx_crc_data_out << 1) ^ (fb ? crc_poly : DW'(0))) & mask;
        limit    = (spi_rnum_max == FW'(0)) ? FW'(1) : spi_rnum_max;
        frm_inc  = FW'(frm_cnt + FW'(1));
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        sr_nxt      = sr;
        frm_cnt_nxt = frm_cnt;
        data_nxt    = spi_rx_data;
        rxne_nxt    = rxne;
        crc_err_nxt = crc_err;
        crc_nxt     = rx_crc_data_out;
        crc_frm_nxt = 1'b0;
        ovr_set     = 1'b0;

        if (txonly) begin
            // Receive path parked; any partial frame is dropped
            bit_cnt_nxt = '0;
            sr_nxt      = '0;
        end else begin
            bit_cnt_nxt = last ? '0 : CW'(bit_cnt + CW'(1));
            sr_nxt      = last ? '0 : sr_in;
            if (crc_en && state == ST_DATA) begin
                crc_nxt = crc_step;
            end
            if (last) begin
                if (!rxne || rx_rd_clr) begin
                    data_nxt = frame;
                    rxne_nxt = 1'b1;
                end else begin
                    ovr_set = 1'b1;
                end
                if (crc_en) begin
                    if (state == ST_CRC) begin
                        crc_frm_nxt = 1'b1;
                        if (frame != rx_crc_data_out) begin
                            crc_err_nxt = 1'b1;
                        end
                        crc_nxt     = '0;
                        frm_cnt_nxt = '0;
                        state_nxt   = ST_DATA;
                    end else begin
                        frm_cnt_nxt = frm_inc;
                        if (frm_inc >= limit) begin
                            state_nxt = ST_CRC;
                        end
                    end
                end
            end else if (rx_rd_clr) begin
                rxne_nxt = 1'b0;
            end
        end

        ovr_nxt = ovr_set ? 1'b1 : (ovr_clr ? 1'b0 : ovr);

        if (!crc_en) begin
            state_nxt   = ST_DATA;
            crc_nxt     = '0;
            frm_cnt_nxt = '0;
            crc_err_nxt = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge sclk_rx or negedge spi_rx_rstn) begin
        if (!spi_rx_rstn) begin
            state           <= ST_DATA;
            bit_cnt         <= '0;
            sr              <= '0;
            frm_cnt         <= '0;
            spi_rx_data     <= '0;
            rxne            <= 1'b0;
            ovr             <= 1'b0;
            crc_err         <= 1'b0;
            rx_crc_data_out <= '0;
            rx_crc_frm      <= 1'b0;
        end else begin
            state           <= state_nxt;
            bit_cnt         <= bit_cnt_nxt;
            sr              <= sr_nxt;
            frm_cnt         <= frm_cnt_nxt;
            spi_rx_data     <= data_nxt;
            rxne            <= rxne_nxt;
            ovr             <= ovr_nxt;
            crc_err         <= crc_err_nxt;
            rx_crc_data_out <= crc_nxt;
            rx_crc_frm      <= crc_frm_nxt;
        end
    end

endmodule

// File: tb/tb_spi_rxc.sv
// Self-checking bench for spi_rxc: table of frames through a scoreboard queue,
// plus hand sequences for overrun, CRC, reset and txonly behaviour.
module tb_spi_rxc;

    logic        sclk_rx;
    logic        spi_rx_rstn;
    logic        shift_in;
    logic [1:0]  df;
    logic        lsbf;
    logic        crc_en;
    logic        txonly;
    logic [12:0] spi_rnum_max;
    logic [31:0] crc_poly;
    logic        rx_rd_clr;
    logic        ovr_clr;
    logic [31:0] spi_rx_data;
    logic        rxne;
    logic        ovr;
    logic        crc_err;
    logic [31:0] rx_crc_data_out;
    logic        rx_crc_frm;

    spi_rxc dut (
        .sclk_rx         (sclk_rx),
        .spi_rx_rstn     (spi_rx_rstn),
        .shift_in        (shift_in),
        .df              (df),
        .lsbf            (lsbf),
        .crc_en          (crc_en),
        .txonly          (txonly),
        .spi_rnum_max    (spi_rnum_max),
        .crc_poly        (crc_poly),
        .rx_rd_clr       (rx_rd_clr),
        .ovr_clr         (ovr_clr),
        .spi_rx_data     (spi_rx_data),
        .rxne            (rxne),
        .ovr             (ovr),
        .crc_err         (crc_err),
        .rx_crc_data_out (rx_crc_data_out),
        .rx_crc_frm      (rx_crc_frm)
    );

    typedef struct {
        logic [1:0]  df;
        logic        lsbf;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl [6];
    logic [31:0] exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One SPI bit clock; outputs are sampled after it while sclk_rx is low
    task automatic edge_clk();
        #5 sclk_rx = 1'b1;
        #5 sclk_rx = 1'b0;
    endtask

    task automatic pulse_reset();
        spi_rx_rstn = 1'b0;
        #2;
        spi_rx_rstn = 1'b1;
        #1;
    endtask

    function automatic int nbits(input logic [1:0] d);
        return (d == 2'b00) ? 8 : (d == 2'b01) ? 16 : 32;
    endfunction

    function automatic logic bit_of(input logic [31:0] data, input int k, input int n, input logic lf);
        logic [31:0] d;
        d = data;
        return lf ? d[k] : d[n-1-k];
    endfunction

    task automatic send_bits(input logic [31:0] data, input int first, input int count,
                             input int clr_at, input int oclr_at);
        int n;
        n = nbits(df);
        for (int k = first; k < first + count; k++) begin
            shift_in  = bit_of(data, k, n, lsbf);
            rx_rd_clr = (k == clr_at);
            ovr_clr   = (k == oclr_at);
            edge_clk();
        end
        rx_rd_clr = 1'b0;
        ovr_clr   = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] data, input int clr_at, input int oclr_at);
        send_bits(data, 0, nbits(df), clr_at, oclr_at);
    endtask

    // Reference CRC over one MSB-first frame
    function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [31:0] d,
                                              input int n, input logic [31:0] poly);
        logic [31:0] c, m;
        logic        b, f;
        m = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        c = c_in;
        for (int k = n - 1; k >= 0; k--) begin
            b = d[k];
            f = c[n-1] ^ b;
            c = ((c << 1) ^ (f ? poly : 32'd0)) & m;
        end
        return c;
    endfunction

    initial begin
        logic [31:0] exp_crc;
        sclk_rx = 1'b0; spi_rx_rstn = 1'b0; shift_in = 1'b0;
        df = 2'b00; lsbf = 1'b0; crc_en = 1'b0; txonly = 1'b0;
        spi_rnum_max = 13'd0; crc_poly = 32'd0; rx_rd_clr = 1'b0; ovr_clr = 1'b0;
        #3;
        check("reset_data", spi_rx_data, 32'h0);
        check("reset_rxne", rxne, 1'b0);
        check("reset_ovr", ovr, 1'b0);
        check("reset_crc_err", crc_err, 1'b0);
        check("reset_crc", rx_crc_data_out, 32'h0);
        check("reset_crc_frm", rx_crc_frm, 1'b0);
        spi_rx_rstn = 1'b1;
        #1;

        // 0xA5 MSB first: rxne appears only after the 8th edge
        send_bits(32'hA5, 0, 7, -1, -1);
        check("a5_rxne_before_last", rxne, 1'b0);
        send_bits(32'hA5, 7, 1, -1, -1);
        check("a5_rxne", rxne, 1'b1);
        check("a5_data", spi_rx_data, 32'h0000_00A5);

        tbl[0] = '{2'b00, 1'b0, 32'h0000_00A5, 32'h0000_00A5};
        tbl[1] = '{2'b01, 1'b1, 32'h0000_1234, 32'h0000_1234};
        tbl[2] = '{2'b10, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[3] = '{2'b11, 1'b1, 32'h8000_0001, 32'h8000_0001};
        tbl[4] = '{2'b00, 1'b1, 32'hFFFF_FF5A, 32'h0000_005A};
        tbl[5] = '{2'b01, 1'b0, 32'hABCD_8001, 32'h0000_8001};

        // Back-to-back frames, each read released on bit 0 of the next
        for (int i = 0; i < 6; i++) begin
            df   = tbl[i].df;
            lsbf = tbl[i].lsbf;
            exp_q.push_back(tbl[i].exp);
            send_bits(tbl[i].data, 0, 1, 0, -1);
            check($sformatf("tbl%0d_rxne_cleared", i), rxne, 1'b0);
            send_bits(tbl[i].data, 1, nbits(df) - 1, -1, -1);
            check($sformatf("tbl%0d_rxne", i), rxne, 1'b1);
            check($sformatf("tbl%0d_ovr", i), ovr, 1'b0);
            if (exp_q.size() == 0) begin
                check($sformatf("tbl%0d_queue_empty", i), 32'd1, 32'd0);
            end else begin
                check($sformatf("tbl%0d_data", i), spi_rx_data, exp_q.pop_front());
            end
        end

        // Overrun: second frame unread keeps the first, sets ovr
        pulse_reset();
        df = 2'b00; lsbf = 1'b0;
        send_frame(32'h11, -1, -1);
        send_frame(32'h22, -1, -1);
        check("ovr_set", ovr, 1'b1);
        check("ovr_data_hold", spi_rx_data, 32'h11);
        check("ovr_rxne", rxne, 1'b1);
        send_frame(32'h33, 7, 0);
        check("ovr_cleared", ovr, 1'b0);
        check("clr_on_last_data", spi_rx_data, 32'h33);
        check("clr_on_last_rxne", rxne, 1'b1);
        send_frame(32'h44, -1, 7);
        check("ovr_set_wins", ovr, 1'b1);
        check("ovr2_data_hold", spi_rx_data, 32'h33);

        // CRC: poly 0x07, one data frame per block
        pulse_reset();
        df = 2'b00; lsbf = 1'b0; crc_en = 1'b1; crc_poly = 32'h07; spi_rnum_max = 13'd1;
        send_frame(32'h01, -1, -1);
        check("crc_after_01", rx_crc_data_out, 32'h07);
        check("crc_frm_on_data", rx_crc_frm, 1'b0);
        send_frame(32'h07, 0, -1);
        check("crc_frm_pulse", rx_crc_frm, 1'b1);
        check("crc_err_good", crc_err, 1'b0);
        check("crc_frame_data", spi_rx_data, 32'h07);
        check("crc_reset_after", rx_crc_data_out, 32'h0);
        send_frame(32'h01, 0, -1);
        check("crc_frm_single", rx_crc_frm, 1'b0);
        send_frame(32'h08, 0, -1);
        check("crc_frm_pulse2", rx_crc_frm, 1'b1);
        check("crc_err_bad", crc_err, 1'b1);
        send_frame(32'h55, 0, -1);
        check("crc_err_sticky", crc_err, 1'b1);

        // Two data frames per block; spi_rnum_max switched between blocks
        pulse_reset();
        spi_rnum_max = 13'd2;
        exp_crc = crc_model(32'h0, 32'h01, 8, 32'h07);
        exp_crc = crc_model(exp_crc, 32'h02, 8, 32'h07);
        send_frame(32'h01, -1, -1);
        send_frame(32'h02, 0, -1);
        check("crc2_value", rx_crc_data_out, exp_crc);
        check("crc2_no_frm_yet", rx_crc_frm, 1'b0);
        send_frame(exp_crc, 0, -1);
        check("crc2_frm", rx_crc_frm, 1'b1);
        check("crc2_err", crc_err, 1'b0);
        crc_en = 1'b0;
        send_frame(32'h01, 0, -1);
        check("crc_off_value", rx_crc_data_out, 32'h0);
        check("crc_off_frm", rx_crc_frm, 1'b0);

        // Reset mid-frame, then a clean frame
        pulse_reset();
        send_bits(32'hFF, 0, 5, -1, -1);
        pulse_reset();
        check("midreset_rxne", rxne, 1'b0);
        send_frame(32'h3C, -1, -1);
        check("midreset_data", spi_rx_data, 32'h3C);
        check("midreset_ovr", ovr, 1'b0);

        // txonly: no reception, partial frame discarded, rxne held
        pulse_reset();
        txonly = 1'b1;
        send_frame(32'hFF, -1, -1);
        check("txonly_rxne", rxne, 1'b0);
        check("txonly_data", spi_rx_data, 32'h0);
        txonly = 1'b0;
        send_bits(32'hFF, 0, 3, -1, -1);
        txonly = 1'b1;
        edge_clk();
        txonly = 1'b0;
        send_frame(32'h96, -1, -1);
        check("partial_discard", spi_rx_data, 32'h96);
        txonly = 1'b1;
        rx_rd_clr = 1'b1;
        edge_clk();
        rx_rd_clr = 1'b0;
        txonly = 1'b0;
        check("txonly_rxne_hold", rxne, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
